param_load_counter: RTL and testbench
=====================================

PARAM_LOAD_COUNTER -- requirements
Module: param_load_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter width in bits (>=2).
REQ-002 SHALL have parameter RESET_VAL, default all ones ({WIDTH{1'b1}}), value of count and reload register after reset.
REQ-003 SHALL have parameter TC_VAL, default 1, terminal value in down mode.
REQ-004 SHALL have parameter PRESCALE, default 4, tick divisor (used only when PLCNT_PRESCALE_EN is defined).
REQ-005 SHALL have port clock  in  1  rising-edge clock.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port clkEN  in  1  global enable; load and step act only when high.
REQ-008 SHALL have port ldcnt  in  1  load request.
REQ-009 SHALL have port NumData  in  WIDTH  load value.
REQ-010 SHALL have port cnt_en  in  1  count enable.
REQ-011 SHALL have port up  in  1  direction: 1 up, 0 down; sampled at each step.
REQ-012 SHALL have port auto_rl  in  1  1 auto-reload at terminal, 0 one-shot.
REQ-013 SHALL have port count  out  WIDTH  current count (registered).
REQ-014 SHALL have port co  out  1  combinational: count == terminal value for current direction.
REQ-015 SHALL have port tc_pulse  out  1  registered one-cycle pulse when a step occurs from the terminal value.
REQ-016 SHALL have port done  out  1  high while FSM is in HOLD.

Function
REQ-017 Terminal value SHALL be TC_VAL when up=0 and {WIDTH{1'b1}} when up=1.
REQ-018 FSM SHALL have states IDLE, RUN, HOLD; IDLE and HOLD never step.
REQ-019 Load (clkEN & ldcnt) SHALL, from any state, set count=NumData, reload register=NumData, state=RUN, on the next edge.
REQ-020 Step SHALL occur when clkEN & cnt_en & state==RUN & !ldcnt (& prescaler tick when enabled).
REQ-021 Step at non-terminal value SHALL change count by +1 (up) or -1 (down), modulo 2^WIDTH.
REQ-022 Step at terminal value with auto_rl=1 SHALL set count=reload register, stay RUN, pulse tc_pulse.
REQ-023 Step at terminal value with auto_rl=0 SHALL hold count, enter HOLD, pulse tc_pulse.
REQ-024 Load SHALL take priority over step in the same cycle; tc_pulse SHALL then stay 0.
REQ-025 Down-mode load below TC_VAL SHALL wrap through 0 to all ones and continue to TC_VAL.
REQ-026 clkEN=0 SHALL freeze count, state, prescaler; tc_pulse SHALL be 0.

Reset
REQ-027 Reset SHALL immediately set count=RESET_VAL, reload=RESET_VAL, state=IDLE, tc_pulse=0, done=0, prescaler=0, including mid-operation.

Configuration
REQ-028 With PLCNT_PRESCALE_EN defined, a step SHALL require an internal prescaler (counts qualified clkEN&cnt_en&RUN cycles) to be at PRESCALE-1, then wrap to 0; load and reset SHALL clear it.
REQ-029 Without PLCNT_PRESCALE_EN, every qualified cycle SHALL step; no prescaler logic; PRESCALE ignored.

Structure
REQ-030 Package plcnt_pkg SHALL hold the FSM state typedef (IDLE, RUN, HOLD) and its 2-bit encodings.
REQ-031 Prescaler SHALL be sub-module plcnt_prescaler, instantiated only under PLCNT_PRESCALE_EN.

Verification
REQ-032 Reset, then cnt_en=1, clkEN=1, no load -> count=4'hF held, done=0, tc_pulse=0.
REQ-033 Load 5, up=0, auto_rl=0 -> 5,4,3,2,1 (co=1 at 1), next edge tc_pulse=1 for one cycle, done=1, count stays 1.
REQ-034 Load 3, up=0, auto_rl=1 -> 3,2,1,3,2,1,...; tc_pulse at each 1->3; done stays 0.
REQ-035 Load 13, up=1, auto_rl=1 -> 13,14,15,13; co=1 at 15; load 9 while count=15 and stepping -> count=9, tc_pulse=0; ldcnt with clkEN=0 -> no change.
REQ-036 PLCNT_PRESCALE_EN, PRESCALE=4: load 8, down, continuous enable -> count decrements every 4th cycle; reset asserted mid-run -> count=4'hF, IDLE, same cycle.

Source files
------------

// File: rtl/plcnt_pkg.sv
// Shared definitions for the loadable up/down counter: FSM encodings and a
// width helper for the optional prescaler.
package plcnt_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    HOLD = ST_HOLD
  } plcnt_state_e;

  // A divisor of 1 still needs a one-bit register so the tick compare is legal.
  function automatic int unsigned prescale_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/plcnt_prescaler.sv
// Step-rate divider: counts qualified cycles and flags the last one of every
// PRESCALE-cycle window. Only instantiated when PLCNT_PRESCALE_EN is defined.
module plcnt_prescaler
  import plcnt_pkg::*;
#(
  parameter int unsigned PRESCALE = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic count_i,
  output logic tick_o
);

  localparam int unsigned    PW   = prescale_w(PRESCALE);
  localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;

  assign tick_o = (pre_q == LAST);

  always_comb begin
    pre_d = pre_q;
    if (clear_i) begin
      pre_d = '0;
    end else if (count_i) begin
      pre_d = tick_o ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

endmodule

// File: rtl/param_load_counter.sv
// Loadable up/down counter with auto-reload or one-shot terminal handling.
// Optional step prescaler enabled by defining PLCNT_PRESCALE_EN.
module param_load_counter
  import plcnt_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] TC_VAL    = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int unsigned      PRESCALE  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clkEN,
  input  logic             ldcnt,
  input  logic [WIDTH-1:0] NumData,
  input  logic             cnt_en,
  input  logic             up,
  input  logic             auto_rl,
  output logic [WIDTH-1:0] count,
  output logic             co,
  output logic             tc_pulse,
  output logic             done
);

  logic [WIDTH-1:0] count_q,  count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  plcnt_state_e     state_q,  state_d;
  logic             tc_q,     tc_d;

  logic             load;
  logic             qual;
  logic             tick;
  logic             step;
  logic [WIDTH-1:0] term;

  assign load = clkEN & ldcnt;
  assign qual = clkEN & cnt_en & (state_q == RUN);
  assign step = qual & ~ldcnt & tick;
  assign term = up ? {WIDTH{1'b1}} : TC_VAL;

`ifdef PLCNT_PRESCALE_EN
  plcnt_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock   (clock),
    .reset   (reset),
    .clear_i (load),
    .count_i (qual),
    .tick_o  (tick)
  );
`else
  // Every qualified cycle steps; the divisor has no effect in this build.
  logic unused_prescale;
  assign unused_prescale = ^PRESCALE;
  assign tick            = 1'b1;
`endif

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    state_d  = state_q;
    tc_d     = 1'b0;
    if (load) begin
      count_d  = NumData;
      reload_d = NumData;
      state_d  = RUN;
    end else if (step) begin
      if (count_q == term) begin
        tc_d = 1'b1;
        if (auto_rl) begin
          count_d = reload_q;
        end else begin
          state_d = HOLD;
        end
      end else if (up) begin
        count_d = count_q + 1'b1;
      end else begin
        // Loads below TC_VAL wrap through zero on their way down.
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q  <= RESET_VAL;
      reload_q <= RESET_VAL;
      state_q  <= IDLE;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      state_q  <= state_d;
      tc_q     <= tc_d;
    end
  end

  assign count    = count_q;
  assign co       = (count_q == term);
  assign tc_pulse = tc_q;
  assign done     = (state_q == HOLD);

endmodule

// File: tb/tb_param_load_counter.sv
// Self-checking bench for param_load_counter with a cycle-level reference model.
module tb_param_load_counter;

`ifdef PLCNT_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif
  localparam int MOD    = 16;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_HOLD = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clkEN = 1'b0;
  logic       ldcnt = 1'b0;
  logic [3:0] NumData = 4'd0;
  logic       cnt_en = 1'b0;
  logic       up = 1'b0;
  logic       auto_rl = 1'b0;
  logic [3:0] count;
  logic       co;
  logic       tc_pulse;
  logic       done;

  int checks = 0;
  int failures = 0;

  int m_count, m_reload, m_state, m_ps;
  bit m_tc;

  param_load_counter #(
    .WIDTH    (4),
    .PRESCALE (4)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .clkEN    (clkEN),
    .ldcnt    (ldcnt),
    .NumData  (NumData),
    .cnt_en   (cnt_en),
    .up       (up),
    .auto_rl  (auto_rl),
    .count    (count),
    .co       (co),
    .tc_pulse (tc_pulse),
    .done     (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int term_of(input bit u);
    return u ? MOD - 1 : 1;
  endfunction

  task automatic model_reset();
    m_count  = MOD - 1;
    m_reload = MOD - 1;
    m_state  = S_IDLE;
    m_ps     = 0;
    m_tc     = 0;
  endtask

  // Reference behaviour for one rising edge, given the inputs now applied.
  task automatic model_edge();
    bit tick;
    m_tc = 0;
    if (!clkEN) return;
    if (ldcnt) begin
      m_count  = NumData;
      m_reload = NumData;
      m_state  = S_RUN;
      m_ps     = 0;
      return;
    end
    if (cnt_en && m_state == S_RUN) begin
      tick = (m_ps == PS - 1);
      m_ps = tick ? 0 : m_ps + 1;
      if (tick) begin
        if (m_count == term_of(up)) begin
          m_tc = 1;
          if (auto_rl) m_count = m_reload;
          else         m_state = S_HOLD;
        end else if (up) begin
          m_count = (m_count + 1) % MOD;
        end else begin
          m_count = (m_count + MOD - 1) % MOD;
        end
      end
    end
  endtask

  task automatic clk_cycle();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    checks++;
    if (count !== 4'hF || done !== 1'b0 || tc_pulse !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: count=%h done=%b tc=%b expected count=f done=0 tc=0", count, done, tc_pulse);
    end
    @(negedge clock);
    reset = 1'b0;
    cnt_en = 1'b1; clkEN = 1'b1; ldcnt = 1'b0; up = 1'b0;
    for (int i = 0; i < 6; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'hF || done !== 1'b0 || tc_pulse !== 1'b0) begin
        failures++;
        $display("FAIL idle_no_step: cycle=%0d count=%h done=%b tc=%b expected count=f done=0 tc=0", i, count, done, tc_pulse);
      end
    end
  endtask

  task automatic test_down_oneshot();
    int pulses = 0;
    up = 1'b0; auto_rl = 1'b0; cnt_en = 1'b1; clkEN = 1'b1;
    ldcnt = 1'b1; NumData = 4'd5;
    clk_cycle();
    ldcnt = 1'b0;
    checks++;
    if (count !== 4'd5) begin
      failures++;
      $display("FAIL oneshot_load: count=%h expected 5", count);
    end
    for (int i = 0; i < 60 && m_state != S_HOLD; i++) begin
      if (count == 4'd1) begin
        checks++;
        if (co !== 1'b1) begin
          failures++;
          $display("FAIL oneshot_co: co=%b expected 1 at count 1", co);
        end
      end
      clk_cycle();
      if (tc_pulse) pulses++;
      checks++;
      if (count !== 4'(m_count) || tc_pulse !== m_tc || done !== (m_state == S_HOLD)) begin
        failures++;
        $display("FAIL oneshot_seq: count=%h tc=%b done=%b expected count=%h tc=%b done=%b",
                 count, tc_pulse, done, 4'(m_count), m_tc, m_state == S_HOLD);
      end
    end
    repeat (3) clk_cycle();
    checks++;
    if (count !== 4'd1 || done !== 1'b1 || tc_pulse !== 1'b0 || pulses != 1) begin
      failures++;
      $display("FAIL oneshot_hold: count=%h done=%b tc=%b pulses=%0d expected count=1 done=1 tc=0 pulses=1",
               count, done, tc_pulse, pulses);
    end
  endtask

  task automatic test_down_autoreload();
    int pulses = 0;
    int m_pulses = 0;
    up = 1'b0; auto_rl = 1'b1; cnt_en = 1'b1; clkEN = 1'b1;
    ldcnt = 1'b1; NumData = 4'd3;
    clk_cycle();
    ldcnt = 1'b0;
    checks++;
    if (count !== 4'd3 || done !== 1'b0) begin
      failures++;
      $display("FAIL autorl_load: count=%h done=%b expected 3 0", count, done);
    end
    for (int i = 0; i < 12 * PS; i++) begin
      clk_cycle();
      if (tc_pulse) pulses++;
      if (m_tc) m_pulses++;
      checks++;
      if (count !== 4'(m_count) || tc_pulse !== m_tc || done !== 1'b0) begin
        failures++;
        $display("FAIL autorl_seq: count=%h tc=%b done=%b expected count=%h tc=%b done=0",
                 count, tc_pulse, done, 4'(m_count), m_tc);
      end
    end
    checks++;
    if (pulses != m_pulses || pulses < 3) begin
      failures++;
      $display("FAIL autorl_pulses: got=%0d expected=%0d", pulses, m_pulses);
    end
  endtask

  task automatic test_up_load_priority();
    int guard = 0;
    up = 1'b1; auto_rl = 1'b1; cnt_en = 1'b1; clkEN = 1'b1;
    ldcnt = 1'b1; NumData = 4'd13;
    clk_cycle();
    ldcnt = 1'b0;
    checks++;
    if (count !== 4'd13) begin
      failures++;
      $display("FAIL up_load: count=%h expected d", count);
    end
    for (int i = 0; i < 8 * PS; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'(m_count) || tc_pulse !== m_tc || co !== (m_count == 15)) begin
        failures++;
        $display("FAIL up_seq: count=%h tc=%b co=%b expected count=%h tc=%b co=%b",
                 count, tc_pulse, co, 4'(m_count), m_tc, m_count == 15);
      end
    end
    while (m_count != 15 && guard < 40) begin
      clk_cycle();
      guard++;
    end
    checks++;
    if (count !== 4'hF || co !== 1'b1) begin
      failures++;
      $display("FAIL up_terminal: count=%h co=%b expected f 1", count, co);
    end
    ldcnt = 1'b1; NumData = 4'd9;
    clk_cycle();
    checks++;
    if (count !== 4'd9 || tc_pulse !== 1'b0) begin
      failures++;
      $display("FAIL load_priority: count=%h tc=%b expected count=9 tc=0", count, tc_pulse);
    end
    clkEN = 1'b0; NumData = 4'd2;
    for (int i = 0; i < 4; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'd9 || tc_pulse !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL clken_freeze: count=%h tc=%b done=%b expected count=9 tc=0 done=0", count, tc_pulse, done);
      end
    end
    ldcnt = 1'b0; clkEN = 1'b1;
  endtask

  task automatic test_wrap_below_tc();
    int guard = 0;
    up = 1'b0; auto_rl = 1'b0; cnt_en = 1'b1; clkEN = 1'b1;
    ldcnt = 1'b1; NumData = 4'd0;
    clk_cycle();
    ldcnt = 1'b0;
    clk_cycle();
    while (m_state != S_HOLD && guard < 20 * PS) begin
      checks++;
      if (count !== 4'(m_count)) begin
        failures++;
        $display("FAIL wrap_seq: count=%h expected %h", count, 4'(m_count));
      end
      clk_cycle();
      guard++;
    end
    checks++;
    if (count !== 4'd1 || done !== 1'b1 || guard < 14) begin
      failures++;
      $display("FAIL wrap_end: count=%h done=%b steps=%0d expected count=1 done=1 steps>=14", count, done, guard);
    end
  endtask

  task automatic test_reset_mid_run();
    up = 1'b0; auto_rl = 1'b1; cnt_en = 1'b1; clkEN = 1'b1;
    ldcnt = 1'b1; NumData = 4'd8;
    clk_cycle();
    ldcnt = 1'b0;
    for (int i = 0; i < 4 * PS + 1; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'(m_count)) begin
        failures++;
        $display("FAIL prerst_seq: count=%h expected %h", count, 4'(m_count));
      end
    end
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (count !== 4'hF || done !== 1'b0 || tc_pulse !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: count=%h done=%b tc=%b expected count=f done=0 tc=0", count, done, tc_pulse);
    end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      clk_cycle();
      checks++;
      if (count !== 4'hF || done !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle: count=%h done=%b expected f 0", count, done);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      clkEN   = ($urandom_range(7) != 0);
      cnt_en  = ($urandom_range(7) != 0);
      ldcnt   = ($urandom_range(11) == 0);
      NumData = 4'($urandom_range(15));
      auto_rl = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) up = ~up;
      clk_cycle();
      checks++;
      if (count !== 4'(m_count) || tc_pulse !== m_tc || done !== (m_state == S_HOLD) ||
          co !== (m_count == term_of(up))) begin
        failures++;
        $display("FAIL random: i=%0d count=%h tc=%b done=%b co=%b expected count=%h tc=%b done=%b co=%b",
                 i, count, tc_pulse, done, co, 4'(m_count), m_tc, m_state == S_HOLD, m_count == term_of(up));
      end
    end
    ldcnt = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_down_oneshot();
    test_down_autoreload();
    test_up_load_priority();
    test_wrap_below_tc();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
